// File: rtl/lc3b_types.sv
// ----------------------------------------------------------------------------
// lc3b_types
//   Shared LC-3b types for the pipeline: word/byte types, the opcode encoding,
//   the control word carried through EX/MEM, the MEM-stage controller state
//   encoding and the byte-select helper used for LDB formatting.
// ----------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [7:0]  lc3b_byte;

    // Byte-enable value that selects both lanes of a word access.
    localparam logic [1:0] BE_ALL = 2'b11;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode opcode;
        logic       mem_read;
        logic       mem_write;
    } lc3b_control_word;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        PTR  = 3'd2,
        IND  = 3'd3,
        DONE = 3'd4
    } mem_state_t;

    // Pick the high byte for odd addresses, the low byte for even ones.
    function automatic lc3b_byte lc3b_byte_sel(input lc3b_word word, input logic odd);
        lc3b_byte sel;
        if (odd) begin
            sel = word[15:8];
        end else begin
            sel = word[7:0];
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// ----------------------------------------------------------------------------
// mem_load_fmt
//   Combinational load-data formatter for the MEM stage.
//   Ports:
//     rdata     in  word   raw cache read data
//     byte_load in  1      1 = LDB (select one byte and zero-extend)
//     odd       in  1      address bit 0, selects the high byte when set
//     fmt_data  out word   formatted load result
// ----------------------------------------------------------------------------
module mem_load_fmt
    import lc3b_types::*;
(
    input  lc3b_word rdata,
    input  logic     byte_load,
    input  logic     odd,
    output lc3b_word fmt_data
);

    // Byte loads are zero-extended; word loads pass through untouched.
    always_comb begin
        fmt_data = rdata;
        if (byte_load) begin
            fmt_data = {8'h00, lc3b_byte_sel(rdata, odd)};
        end else begin
            fmt_data = rdata;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl
//   MEM-stage controller behind the EX/MEM register. Runs the data-cache
//   request/response handshake for LDR/LDB/STR/STB (one access) and LDI/STI
//   (pointer read, then indirect access), stalls the pipeline until the last
//   access completes, and registers formatted load data for MEM/WB.
//   Non-memory ops pass through without stalling.
//
//   Optional feature: define MEM_PERF_CNT_EN to add the saturating
//   stall_cycles counter port (parameter PCNT_W sets its width).
//
//   Ports:
//     clk, reset_n                clock, async active-low reset
//     cw_in, addr_in, wdata_in,   op from EX/MEM (control word, effective
//     be_in                       address, store data, byte enables)
//     flush                       squash the op currently in MEM
//     dcache_resp, dcache_rdata   cache completion and read data
//     dcache_read/write/address/  cache request, held until response
//     wdata/byte_en
//     stall_mem                   freeze IF..EX/MEM
//     mem_rdata_out               registered formatted load data
//     mem_done                    one-cycle pulse when a memory op retires
//     stall_cycles                (MEM_PERF_CNT_EN) stall cycle count
// ----------------------------------------------------------------------------
module mem_stage_ctrl
    import lc3b_types::*;
#(
    parameter int WORD_W = 16
`ifdef MEM_PERF_CNT_EN
    , parameter int PCNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  lc3b_control_word  cw_in,
    input  logic [WORD_W-1:0] addr_in,
    input  logic [WORD_W-1:0] wdata_in,
    input  logic [1:0]        be_in,
    input  logic              flush,
    input  logic              dcache_resp,
    input  logic [WORD_W-1:0] dcache_rdata,
    output logic              dcache_read,
    output logic              dcache_write,
    output logic [WORD_W-1:0] dcache_address,
    output logic [WORD_W-1:0] dcache_wdata,
    output logic [1:0]        dcache_byte_en,
    output logic              stall_mem,
    output logic [WORD_W-1:0] mem_rdata_out,
    output logic              mem_done
`ifdef MEM_PERF_CNT_EN
    , output logic [PCNT_W-1:0] stall_cycles
`endif
);

    mem_state_t state_q, state_d;
    mem_state_t phase_s;

    // Request captured while idle so it cannot drift during the wait.
    lc3b_opcode        op_q, op_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [1:0]        be_q, be_d;

    logic [WORD_W-1:0] ptr_q, ptr_d;
    logic              flushed_q, flushed_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;

    lc3b_opcode        src_op_s;
    logic              src_rd_s;
    logic              src_wr_s;
    logic [WORD_W-1:0] src_addr_s;
    logic [WORD_W-1:0] src_wdata_s;
    logic [1:0]        src_be_s;

    logic              mem_op_s;
    logic              issue_s;
    logic              ind_op_s;
    logic              busy_s;
    logic              flush_eff_s;
    lc3b_word          fmt_s;

    logic              req_rd_s;
    logic              req_wr_s;
    logic [WORD_W-1:0] req_addr_s;
    logic [WORD_W-1:0] req_wdata_s;
    logic [1:0]        req_be_s;

    // Idle uses the live EX/MEM fields (request goes out the same cycle);
    // once busy, the captured copy drives everything.
    always_comb begin
        src_op_s    = op_q;
        src_rd_s    = rd_q;
        src_wr_s    = wr_q;
        src_addr_s  = addr_q;
        src_wdata_s = wdata_q;
        src_be_s    = be_q;
        if (state_q == IDLE) begin
            src_op_s    = cw_in.opcode;
            src_rd_s    = cw_in.mem_read;
            src_wr_s    = cw_in.mem_write;
            src_addr_s  = addr_in;
            src_wdata_s = wdata_in;
            src_be_s    = be_in;
        end else begin
            src_op_s    = op_q;
            src_rd_s    = rd_q;
            src_wr_s    = wr_q;
            src_addr_s  = addr_q;
            src_wdata_s = wdata_q;
            src_be_s    = be_q;
        end
    end

    assign op_d    = src_op_s;
    assign rd_d    = src_rd_s;
    assign wr_d    = src_wr_s;
    assign addr_d  = src_addr_s;
    assign wdata_d = src_wdata_s;
    assign be_d    = src_be_s;

    assign mem_op_s    = cw_in.mem_read | cw_in.mem_write;
    assign issue_s     = (state_q == IDLE) & mem_op_s & ~flush;
    assign ind_op_s    = (src_op_s == op_ldi) | (src_op_s == op_sti);
    assign busy_s      = (state_q == ACC) | (state_q == PTR) | (state_q == IND);
    assign flush_eff_s = flushed_q | flush;

    // Effective phase: an op issuing from IDLE already behaves as its first
    // access state, which lets a 0-wait response be consumed this cycle.
    always_comb begin
        phase_s = state_q;
        if (issue_s) begin
            phase_s = ind_op_s ? PTR : ACC;
        end else begin
            phase_s = state_q;
        end
    end

    mem_load_fmt u_load_fmt (
        .rdata     (dcache_rdata),
        .byte_load (src_op_s == op_ldb),
        .odd       (src_addr_s[0]),
        .fmt_data  (fmt_s)
    );

    // Cache request for the current phase; idle and DONE drive nothing.
    always_comb begin
        req_rd_s    = 1'b0;
        req_wr_s    = 1'b0;
        req_addr_s  = '0;
        req_wdata_s = '0;
        req_be_s    = BE_ALL;
        case (phase_s)
            ACC: begin
                req_rd_s    = src_rd_s;
                req_wr_s    = src_wr_s;
                req_addr_s  = src_addr_s;
                req_wdata_s = src_wdata_s;
                req_be_s    = src_be_s;
            end
            PTR: begin
                // STI arrives flagged as a read: its first access is the pointer fetch.
                req_rd_s    = 1'b1;
                req_addr_s  = src_addr_s;
            end
            IND: begin
                req_rd_s    = (src_op_s == op_ldi);
                req_wr_s    = (src_op_s == op_sti);
                req_addr_s  = ptr_q;
                req_wdata_s = src_wdata_s;
            end
            default: begin
                req_rd_s    = 1'b0;
                req_wr_s    = 1'b0;
            end
        endcase
    end

    // Next-state, pointer capture, load-data update and retire pulse.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        flushed_d = flushed_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        case (phase_s)
            IDLE: begin
                state_d   = IDLE;
                flushed_d = 1'b0;
            end
            ACC: begin
                flushed_d = flush_eff_s;
                if (dcache_resp) begin
                    state_d = DONE;
                    done_d  = ~flush_eff_s;
                    if (src_rd_s && !flush_eff_s) begin
                        rdata_d = fmt_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            PTR: begin
                flushed_d = flush_eff_s;
                if (dcache_resp) begin
                    ptr_d = dcache_rdata;
                    // A squashed STI must not perform its write.
                    if ((src_op_s == op_sti) && flush_eff_s) begin
                        state_d = DONE;
                    end else begin
                        state_d = IND;
                    end
                end else begin
                    state_d = PTR;
                end
            end
            IND: begin
                flushed_d = flush_eff_s;
                if (dcache_resp) begin
                    state_d = DONE;
                    done_d  = ~flush_eff_s;
                    if ((src_op_s == op_ldi) && !flush_eff_s) begin
                        rdata_d = dcache_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = IND;
                end
            end
            DONE: begin
                state_d   = IDLE;
                flushed_d = 1'b0;
            end
            default: begin
                state_d   = IDLE;
                flushed_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= op_br;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= BE_ALL;
            ptr_q     <= '0;
            flushed_q <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            ptr_q     <= ptr_d;
            flushed_q <= flushed_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
        end
    end

    // Outputs; while reset is held any in-flight request is dropped at once,
    // even if EX/MEM still presents a memory op.
    always_comb begin
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        dcache_byte_en = BE_ALL;
        stall_mem      = 1'b0;
        if (!reset_n) begin
            dcache_read    = 1'b0;
            dcache_write   = 1'b0;
            dcache_address = '0;
            dcache_wdata   = '0;
            dcache_byte_en = BE_ALL;
            stall_mem      = 1'b0;
        end else begin
            dcache_read    = req_rd_s;
            dcache_write   = req_wr_s;
            dcache_address = req_addr_s;
            dcache_wdata   = req_wdata_s;
            dcache_byte_en = req_be_s;
            stall_mem      = issue_s | busy_s;
        end
    end

    assign mem_rdata_out = rdata_q;
    assign mem_done      = done_q;

`ifdef MEM_PERF_CNT_EN
    logic [PCNT_W-1:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_mem && (stall_cycles_q != {PCNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + {{(PCNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
    import lc3b_types::*;

    logic             clk = 1'b0;
    logic             reset_n;
    lc3b_control_word cw_in;
    logic [15:0]      addr_in, wdata_in, dcache_rdata, dcache_address, dcache_wdata, mem_rdata_out;
    logic [1:0]       be_in, dcache_byte_en;
    logic             flush, dcache_resp, dcache_read, dcache_write, stall_mem, mem_done;
`ifdef MEM_PERF_CNT_EN
    logic [15:0]      stall_cycles;
`endif

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cw_in          (cw_in),
        .addr_in        (addr_in),
        .wdata_in       (wdata_in),
        .be_in          (be_in),
        .flush          (flush),
        .dcache_resp    (dcache_resp),
        .dcache_rdata   (dcache_rdata),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_byte_en (dcache_byte_en),
        .stall_mem      (stall_mem),
        .mem_rdata_out  (mem_rdata_out),
        .mem_done       (mem_done)
`ifdef MEM_PERF_CNT_EN
        , .stall_cycles (stall_cycles)
`endif
    );

    typedef struct {
        lc3b_opcode  op;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          lat;
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] exp_out;
        int          exp_stall;
        int          exp_acc;
        int          exp_wr;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        logic [1:0]  exp_last_be;
        logic [15:0] exp_last_wdata;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    vec_t vecs[9];
    vec_t sb_q[$];

    // cache model state
    int          lat_g, wait_g, acc_g, wr_cnt_g, stalls_g;
    logic [15:0] rd_g[2];
    logic [15:0] first_addr_g, last_addr_g, last_wdata_g;
    logic [1:0]  last_be_g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input lc3b_opcode op, input logic rd, input logic wr,
                                input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be,
                                input int lat, input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] exp_out, input int exp_stall, input int exp_acc,
                                input int exp_wr, input logic [15:0] exp_last, input logic [1:0] exp_last_be,
                                input logic [15:0] exp_last_wdata);
        vec_t v;
        v.op = op; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.lat = lat; v.r0 = r0; v.r1 = r1; v.exp_out = exp_out; v.exp_stall = exp_stall;
        v.exp_acc = exp_acc; v.exp_wr = exp_wr; v.exp_first = addr; v.exp_last = exp_last;
        v.exp_last_be = exp_last_be; v.exp_last_wdata = exp_last_wdata;
        return v;
    endfunction

    task automatic set_nop();
        cw_in.opcode = op_br; cw_in.mem_read = 1'b0; cw_in.mem_write = 1'b0;
        addr_in = 16'h0000; wdata_in = 16'h0000; be_in = 2'b11;
    endtask

    task automatic cache_reset(input int lat, input logic [15:0] r0, input logic [15:0] r1);
        lat_g = lat; wait_g = 0; acc_g = 0; wr_cnt_g = 0; stalls_g = 0;
        rd_g[0] = r0; rd_g[1] = r1;
        first_addr_g = 16'h0000; last_addr_g = 16'h0000; last_wdata_g = 16'h0000; last_be_g = 2'b00;
    endtask

    // One clock: called just after a falling edge, returns #1 after the rising edge.
    task automatic step();
        #1;
        if (stall_mem) stalls_g++;
        if (dcache_read || dcache_write) begin
            if (acc_g == 0 && wait_g == 0) first_addr_g = dcache_address;
            if (wait_g >= lat_g) begin
                dcache_resp  = 1'b1;
                dcache_rdata = (acc_g == 0) ? rd_g[0] : rd_g[1];
                last_addr_g  = dcache_address;
                last_be_g    = dcache_byte_en;
                if (dcache_write) begin
                    wr_cnt_g++;
                    last_wdata_g = dcache_wdata;
                end
                acc_g++;
                wait_g = 0;
            end else begin
                wait_g++;
            end
        end
        @(posedge clk);
        #1;
        dcache_resp  = 1'b0;
        dcache_rdata = 16'hDEAD;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit   seen;
        vec_t e;
        cache_reset(v.lat, v.r0, v.r1);
        sb_q.push_back(v);
        cw_in.opcode = v.op; cw_in.mem_read = v.rd; cw_in.mem_write = v.wr;
        addr_in = v.addr; wdata_in = v.wdata; be_in = v.be;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            step();
            if (mem_done) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                check($sformatf("v%0d_out", idx), mem_rdata_out, e.exp_out);
                check($sformatf("v%0d_stall_cycles", idx), stalls_g, e.exp_stall);
                check($sformatf("v%0d_accesses", idx), acc_g, e.exp_acc);
                check($sformatf("v%0d_writes", idx), wr_cnt_g, e.exp_wr);
                check($sformatf("v%0d_first_addr", idx), first_addr_g, e.exp_first);
                check($sformatf("v%0d_last_addr", idx), last_addr_g, e.exp_last);
                check($sformatf("v%0d_last_be", idx), last_be_g, e.exp_last_be);
                if (e.exp_wr > 0) check($sformatf("v%0d_wdata", idx), last_wdata_g, e.exp_last_wdata);
                check($sformatf("v%0d_done_stall", idx), stall_mem, 1'b0);
                check($sformatf("v%0d_done_req", idx), {dcache_read, dcache_write}, 2'b00);
                set_nop();
            end
            @(negedge clk);
        end
        if (!seen) begin
            tests_run++; tests_failed++;
            $display("FAIL v%0d_timeout: got no mem_done expected mem_done within 60 cycles", idx);
            void'(sb_q.pop_front());
            set_nop();
        end
        step();
        check($sformatf("v%0d_done_pulse", idx), mem_done, 1'b0);
        check($sformatf("v%0d_no_reissue", idx), acc_g, v.exp_acc);
        @(negedge clk);
    endtask

    initial begin
        //            op      rd    wr    addr      wdata     be     lat r0        r1        out       st acc wr last      lbe    lwdata
        vecs[0] = mk(op_ldr, 1'b1, 1'b0, 16'h3000, 16'h0000, 2'b11, 2, 16'hBEEF, 16'h0000, 16'hBEEF, 3, 1, 0, 16'h3000, 2'b11, 16'h0000);
        vecs[1] = mk(op_ldb, 1'b1, 1'b0, 16'h3001, 16'h0000, 2'b11, 1, 16'h12AB, 16'h0000, 16'h0012, 2, 1, 0, 16'h3001, 2'b11, 16'h0000);
        vecs[2] = mk(op_ldb, 1'b1, 1'b0, 16'h3000, 16'h0000, 2'b11, 0, 16'h12AB, 16'h0000, 16'h00AB, 1, 1, 0, 16'h3000, 2'b11, 16'h0000);
        vecs[3] = mk(op_stb, 1'b0, 1'b1, 16'h4001, 16'h5600, 2'b10, 1, 16'h0000, 16'h0000, 16'h00AB, 2, 1, 1, 16'h4001, 2'b10, 16'h5600);
        vecs[4] = mk(op_ldi, 1'b1, 1'b0, 16'h2000, 16'h0000, 2'b11, 2, 16'h5000, 16'h0042, 16'h0042, 6, 2, 0, 16'h5000, 2'b11, 16'h0000);
        vecs[5] = mk(op_sti, 1'b1, 1'b0, 16'h2000, 16'h7777, 2'b11, 1, 16'h6000, 16'h0000, 16'h0042, 4, 2, 1, 16'h6000, 2'b11, 16'h7777);
        vecs[6] = mk(op_ldi, 1'b1, 1'b0, 16'h1000, 16'h0000, 2'b11, 0, 16'h1234, 16'hABCD, 16'hABCD, 2, 2, 0, 16'h1234, 2'b11, 16'h0000);
        vecs[7] = mk(op_str, 1'b0, 1'b1, 16'h0FFE, 16'hCAFE, 2'b11, 3, 16'h0000, 16'h0000, 16'hABCD, 4, 1, 1, 16'h0FFE, 2'b11, 16'hCAFE);
        vecs[8] = mk(op_ldr, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 2'b11, 0, 16'h1357, 16'h0000, 16'h1357, 1, 1, 0, 16'hFFFF, 2'b11, 16'h0000);

        // reset with a memory op presented: nothing may reach the cache
        reset_n = 1'b0; flush = 1'b0; dcache_resp = 1'b0; dcache_rdata = 16'hDEAD;
        cw_in.opcode = op_ldr; cw_in.mem_read = 1'b1; cw_in.mem_write = 1'b0;
        addr_in = 16'h3000; wdata_in = 16'h1111; be_in = 2'b01;
        cache_reset(0, 16'h0000, 16'h0000);
        #3;
        check("rst_read", dcache_read, 1'b0);
        check("rst_write", dcache_write, 1'b0);
        check("rst_addr", dcache_address, 16'h0000);
        check("rst_wdata", dcache_wdata, 16'h0000);
        check("rst_be", dcache_byte_en, 2'b11);
        check("rst_stall", stall_mem, 1'b0);
        check("rst_out", mem_rdata_out, 16'h0000);
        check("rst_done", mem_done, 1'b0);
        set_nop();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // non-memory op passes through
        cw_in.opcode = op_add;
        step();
        check("alu_stall", stall_mem, 1'b0);
        check("alu_req", {dcache_read, dcache_write}, 2'b00);
        @(negedge clk);

        // flushed memory op in IDLE issues nothing
        cw_in.opcode = op_ldr; cw_in.mem_read = 1'b1; addr_in = 16'h3000; flush = 1'b1;
        #1;
        check("flush_idle_stall", stall_mem, 1'b0);
        check("flush_idle_req", dcache_read, 1'b0);
        @(posedge clk); #1;
        check("flush_idle_stay", dcache_read, 1'b0);
        flush = 1'b0; set_nop();
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // reset while waiting on the LDI pointer read
        cache_reset(10, 16'h5000, 16'h0042);
        cw_in.opcode = op_ldi; cw_in.mem_read = 1'b1; addr_in = 16'h2000; be_in = 2'b11;
        step();
        @(negedge clk);
        #1;
        check("ptr_wait_read", dcache_read, 1'b1);
        check("ptr_wait_addr", dcache_address, 16'h2000);
        reset_n = 1'b0;
        #1;
        check("midrst_read", dcache_read, 1'b0);
        check("midrst_stall", stall_mem, 1'b0);
        check("midrst_out", mem_rdata_out, 16'h0000);
        set_nop();
        @(negedge clk);
        reset_n = 1'b1;
        cache_reset(0, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("postrst_req%0d", i), {dcache_read, dcache_write}, 2'b00);
            check($sformatf("postrst_stall%0d", i), stall_mem, 1'b0);
            @(negedge clk);
        end
        check("postrst_acc", acc_g, 0);

        // flush during the STI pointer read: no write, no mem_done
        cache_reset(1, 16'h6000, 16'h0000);
        cw_in.opcode = op_sti; cw_in.mem_read = 1'b1; addr_in = 16'h2000; wdata_in = 16'h7777;
        step();
        @(negedge clk);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("sti_flush_done", mem_done, 1'b0);
        check("sti_flush_stall", stall_mem, 1'b0);
        set_nop();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("sti_flush_nodone%0d", i), mem_done, 1'b0);
            @(negedge clk);
        end
        check("sti_flush_acc", acc_g, 1);
        check("sti_flush_writes", wr_cnt_g, 0);
        check("sti_flush_out", mem_rdata_out, 16'h0000);

        // normal operation resumes
        run_vec(9, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
